// File: rtl/stopwatch_pkg.sv
// ------------------------------------------------------------------
// stopwatch_pkg: state encoding and clock-rate constants. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STOP = 2'b10,
    S_OVF  = 2'b11
  } state_t;

  localparam int DEFAULT_CLK_HZ          = 50_000_000;
  localparam int DEFAULT_TICK_HZ         = 100;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ------------------------------------------------------------------
// button_debounce: 2-FF sync, debounce counter, press pulse. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= 2'b11;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_n};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Only a released-to-pressed transition is reported.
        stable <= sync[1];
        cnt    <= '0;
        press  <= stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ------------------------------------------------------------------
// stopwatch_ctrl: button handling, run/stop/lap FSM, 100 Hz tick. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = DEFAULT_CLK_HZ,
  parameter int TICK_HZ         = DEFAULT_TICK_HZ,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       CLK_50,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       hold,
  input  logic       overflow_flag,
  output logic       tick,
  output logic       clear_cnt,
  output logic       freeze_display,
  output logic       running,
  output logic [1:0] state
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic             ss_press;
  logic             hold_press;
  state_t           state_q;
  logic [PRE_W-1:0] prescale;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start_stop (
    .clk   (CLK_50),
    .rst_n (reset_n),
    .btn_n (start_stop),
    .press (ss_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hold (
    .clk   (CLK_50),
    .rst_n (reset_n),
    .btn_n (hold),
    .press (hold_press)
  );

  assign state = state_q;

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      prescale       <= '0;
      tick           <= 1'b0;
      clear_cnt      <= 1'b0;
      freeze_display <= 1'b0;
      running        <= 1'b0;
    end else begin
      tick      <= 1'b0;
      clear_cnt <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ss_press) begin
            state_q  <= S_RUN;
            prescale <= '0;
            running  <= 1'b1;
          end else if (hold_press) begin
            clear_cnt <= 1'b1;
          end
        end
        S_RUN: begin
          if (overflow_flag) begin
            state_q        <= S_OVF;
            freeze_display <= 1'b0;
            running        <= 1'b0;
          end else if (ss_press) begin
            state_q <= S_STOP;
            running <= 1'b0;
          end else begin
            // Prescaler only advances while staying in RUN, so no tick leaks out.
            if (hold_press) freeze_display <= ~freeze_display;
            if (prescale == PRE_LAST) begin
              prescale <= '0;
              tick     <= 1'b1;
            end else begin
              prescale <= prescale + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (ss_press) begin
            state_q <= S_RUN;
            running <= 1'b1;
          end else if (hold_press) begin
            if (freeze_display) begin
              freeze_display <= 1'b0;
            end else begin
              clear_cnt <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
        end
        S_OVF: begin
          if (hold_press) begin
            clear_cnt <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ------------------------------------------------------------------
// tb_stopwatch_ctrl: scenario tasks plus random run against a reference model. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DB      = 4;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int HL      = DB + 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ss_n = 1'b1;
  logic       hd_n = 1'b1;
  logic       ovf = 1'b0;
  logic       tick, clear_cnt, freeze_display, running;
  logic [1:0] state;

  int vectors = 0;
  int errors  = 0;

  stopwatch_ctrl #(
    .CLK_HZ          (CLK_HZ),
    .TICK_HZ         (TICK_HZ),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .CLK_50         (clk),
    .reset_n        (reset_n),
    .start_stop     (ss_n),
    .hold           (hd_n),
    .overflow_flag  (ovf),
    .tick           (tick),
    .clear_cnt      (clear_cnt),
    .freeze_display (freeze_display),
    .running        (running),
    .state          (state)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last DB synchronized samples all differ from it;
  // the hundredths phase is RUN residency modulo DIV.
  int          m_state;
  int          m_res;
  logic        m_freeze, m_tick, m_clear;
  logic        ss_evt, hd_evt, ss_stable, hd_stable;
  logic [HL-1:0] ss_h, hd_h;

  function automatic logic [5:0] obs();
    return {state, running, freeze_display, clear_cnt, tick};
  endfunction

  function automatic logic [5:0] exp_v();
    return {2'(m_state), (m_state == 1), m_freeze, m_clear, m_tick};
  endfunction

  function automatic logic db_step(input logic raw, inout logic [HL-1:0] h, inout logic stable);
    logic [DB-1:0] win;
    logic          flip;
    h    = {h[HL-2:0], raw};
    win  = h[HL-1:2];
    flip = stable ? (win == '0) : (win == '1);
    db_step = flip && stable;
    if (flip) stable = ~stable;
  endfunction

  task automatic model_reset();
    m_state = 0; m_res = 0;
    m_freeze = 1'b0; m_tick = 1'b0; m_clear = 1'b0;
    ss_evt = 1'b0; hd_evt = 1'b0;
    ss_stable = 1'b1; hd_stable = 1'b1;
    ss_h = '1; hd_h = '1;
  endtask

  task automatic model_edge();
    logic se, he;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_tick = 1'b0; m_clear = 1'b0;
    case (m_state)
      0: if (ss_evt) begin m_state = 1; m_res = 0; end
         else if (hd_evt) m_clear = 1'b1;
      1: if (ovf) begin m_state = 3; m_freeze = 1'b0; end
         else if (ss_evt) m_state = 2;
         else begin
           if (hd_evt) m_freeze = ~m_freeze;
           m_res++;
           m_tick = (m_res % DIV == 0);
         end
      2: if (ss_evt) m_state = 1;
         else if (hd_evt) begin
           if (m_freeze) m_freeze = 1'b0;
           else begin m_clear = 1'b1; m_state = 0; end
         end
      default: if (hd_evt) begin m_clear = 1'b1; m_state = 0; end
    endcase
    se = db_step(ss_n, ss_h, ss_stable);
    he = db_step(hd_n, hd_h, hd_stable);
    ss_evt = se;
    hd_evt = he;
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    ss_n = 1'b1; hd_n = 1'b1; ovf = 1'b0; reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick_clk();
      vectors++;
      if (obs() !== 6'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b want %b", i, obs(), 6'b0);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_glitch();
    for (int e = 1; e <= 14; e++) begin
      ss_n = !(e <= 3);
      tick_clk();
      vectors++;
      if (obs() !== exp_v() || state !== 2'b00) begin
        errors++;
        $display("FAIL glitch edge%0d: got %b want %b", e, obs(), exp_v());
      end
    end
  endtask

  task automatic test_start();
    int first_tick, nticks;
    first_tick = -1; nticks = 0;
    for (int e = 1; e <= 40; e++) begin
      ss_n = !(e <= 10);
      tick_clk();
      vectors++;
      if (obs() !== exp_v()) begin
        errors++;
        $display("FAIL start edge%0d: got %b want %b", e, obs(), exp_v());
      end
      if (e == 6) begin
        vectors++;
        if (state !== 2'b00) begin errors++; $display("FAIL start_early: state %b want 00", state); end
      end
      if (e == 7) begin
        vectors++;
        if (state !== 2'b01) begin errors++; $display("FAIL start_latency: state %b want 01", state); end
      end
      if (tick === 1'b1) begin
        nticks++;
        if (first_tick < 0) first_tick = e;
      end
    end
    vectors++;
    if (first_tick != 17) begin errors++; $display("FAIL first_tick: edge %0d want 17", first_tick); end
    vectors++;
    if (nticks != 3) begin errors++; $display("FAIL tick_count: got %0d want 3", nticks); end
  endtask

  task automatic test_stop_resume();
    int a, stop_edge, run_edge, tick_edge, exp_gap, stop_ticks;
    a = int'($urandom_range(1, 9));
    stop_edge = -1; run_edge = -1; tick_edge = -1; exp_gap = 0; stop_ticks = 0;
    for (int e = 0; e < 80; e++) begin
      ss_n = !((e >= a && e < a + 8) || (e >= a + 30 && e < a + 38));
      tick_clk();
      vectors++;
      if (obs() !== exp_v()) begin
        errors++;
        $display("FAIL stop_resume edge%0d: got %b want %b", e, obs(), exp_v());
      end
      if (state == 2'b10) begin
        if (stop_edge < 0) begin stop_edge = e; exp_gap = DIV - (m_res % DIV); end
        if (tick === 1'b1) stop_ticks++;
      end
      if (stop_edge >= 0 && run_edge < 0 && state == 2'b01) run_edge = e;
      if (run_edge >= 0 && tick_edge < 0 && tick === 1'b1) tick_edge = e;
    end
    vectors++;
    if (stop_edge != a + 6) begin errors++; $display("FAIL stop_edge: got %0d want %0d", stop_edge, a + 6); end
    vectors++;
    if (run_edge != a + 36) begin errors++; $display("FAIL resume_edge: got %0d want %0d", run_edge, a + 36); end
    vectors++;
    if (stop_ticks != 0) begin errors++; $display("FAIL stop_ticks: got %0d want 0", stop_ticks); end
    vectors++;
    if (tick_edge - run_edge != exp_gap) begin
      errors++;
      $display("FAIL resume_phase: gap %0d want %0d", tick_edge - run_edge, exp_gap);
    end
  endtask

  task automatic test_freeze();
    int clears, frozen_ticks;
    clears = 0; frozen_ticks = 0;
    for (int e = 0; e < 90; e++) begin
      hd_n = !((e >= 2 && e < 10) || (e >= 42 && e < 50) || (e >= 62 && e < 70));
      ss_n = !(e >= 22 && e < 30);
      tick_clk();
      vectors++;
      if (obs() !== exp_v()) begin
        errors++;
        $display("FAIL freeze edge%0d: got %b want %b", e, obs(), exp_v());
      end
      if (clear_cnt === 1'b1) clears++;
      if (tick === 1'b1 && freeze_display === 1'b1) frozen_ticks++;
      if (e == 20) begin
        vectors++;
        if (freeze_display !== 1'b1) begin errors++; $display("FAIL freeze_set: got %b want 1", freeze_display); end
      end
      if (e == 40) begin
        vectors++;
        if (state !== 2'b10) begin errors++; $display("FAIL freeze_stop: state %b want 10", state); end
      end
      if (e == 55) begin
        vectors++;
        if (freeze_display !== 1'b0 || state !== 2'b10) begin
          errors++;
          $display("FAIL unfreeze: freeze %b state %b want 0/10", freeze_display, state);
        end
      end
    end
    vectors++;
    if (frozen_ticks != 2) begin errors++; $display("FAIL frozen_ticks: got %0d want 2", frozen_ticks); end
    vectors++;
    if (clears != 1 || state !== 2'b00) begin
      errors++;
      $display("FAIL freeze_clear: clears %0d state %b want 1/00", clears, state);
    end
  endtask

  task automatic test_overflow();
    int clears, ovf_ticks;
    clears = 0; ovf_ticks = 0;
    for (int e = 0; e < 90; e++) begin
      ss_n = !((e < 8) || (e >= 20 && e < 28) || (e >= 40 && e < 48));
      hd_n = !((e >= 8 && e < 16) || (e >= 60 && e < 68));
      ovf  = (e >= 26 && e < 31);
      tick_clk();
      vectors++;
      if (obs() !== exp_v()) begin
        errors++;
        $display("FAIL overflow edge%0d: got %b want %b", e, obs(), exp_v());
      end
      if (clear_cnt === 1'b1) clears++;
      if (e > 26 && tick === 1'b1) ovf_ticks++;
      if (e == 20) begin
        vectors++;
        if (freeze_display !== 1'b1) begin errors++; $display("FAIL ovf_prefreeze: got %b want 1", freeze_display); end
      end
      if (e == 26) begin
        vectors++;
        if (state !== 2'b11 || freeze_display !== 1'b0) begin
          errors++;
          $display("FAIL ovf_entry: state %b freeze %b want 11/0", state, freeze_display);
        end
      end
      if (e == 55) begin
        vectors++;
        if (state !== 2'b11) begin errors++; $display("FAIL ovf_ignore_ss: state %b want 11", state); end
      end
    end
    ovf = 1'b0;
    vectors++;
    if (ovf_ticks != 0) begin errors++; $display("FAIL ovf_ticks: got %0d want 0", ovf_ticks); end
    vectors++;
    if (clears != 1 || state !== 2'b00) begin
      errors++;
      $display("FAIL ovf_clear: clears %0d state %b want 1/00", clears, state);
    end
  endtask

  task automatic test_random();
    int ss_left, hd_left, ovf_left;
    ss_left = 0; hd_left = 0; ovf_left = 0;
    for (int e = 0; e < 2000; e++) begin
      if (ss_left == 0) begin ss_n = ($urandom_range(0, 1) == 1); ss_left = int'($urandom_range(1, 12)); end
      if (hd_left == 0) begin hd_n = ($urandom_range(0, 1) == 1); hd_left = int'($urandom_range(1, 12)); end
      ss_left--; hd_left--;
      if (ovf_left > 0) ovf_left--;
      else if ($urandom_range(0, 199) == 0) ovf_left = int'($urandom_range(1, 4));
      ovf = (ovf_left > 0);
      tick_clk();
      vectors++;
      if (obs() !== exp_v()) begin
        errors++;
        $display("FAIL random edge%0d: got %b want %b", e, obs(), exp_v());
      end
    end
    ovf = 1'b0;
  endtask

  task automatic test_reset_midop();
    ss_n = 1'b0; hd_n = 1'b1; ovf = 1'b0;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (obs() !== 6'b0) begin errors++; $display("FAIL async_reset: got %b want %b", obs(), 6'b0); end
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick_clk();
      vectors++;
      if (obs() !== 6'b0) begin errors++; $display("FAIL reset_hold cyc%0d: got %b want %b", i, obs(), 6'b0); end
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      ss_n = !(e <= 12);
      tick_clk();
      vectors++;
      if (obs() !== exp_v()) begin
        errors++;
        $display("FAIL post_reset edge%0d: got %b want %b", e, obs(), exp_v());
      end
      if (e == 7) begin
        vectors++;
        if (state !== 2'b01) begin errors++; $display("FAIL held_press: state %b want 01", state); end
      end
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_glitch();
    test_start();
    test_stop_resume();
    test_freeze();
    test_overflow();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
